// File: rtl/pim_encoder_acc.sv
// pim_encoder_acc: per-channel popcount accumulator for PIM buffer outputs.
// Each accepted beat adds the popcount of every channel word (RBR) or of both
// buffer words (PARALLEL) into a per-channel accumulator. A group of
// acc_len_i+1 beats produces one result, held in HOLD until it is consumed.
// Define PIM_ENC_ACC_SAT_EN to saturate accumulators at 2^ACC_W-1; by default
// they wrap modulo 2^ACC_W.
module pim_encoder_acc #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 12,
    parameter int LEN_W  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [2:0]               pim_mode_i,
    input  logic [LEN_W-1:0]         acc_len_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [NUM_CH*DATA_W-1:0] data_1_i,
    input  logic [NUM_CH*DATA_W-1:0] data_2_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [NUM_CH*ACC_W-1:0]  out_data_o,
    output logic                     mode_err_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [2:0] MODE_PAR = 3'b101;
    localparam logic [2:0] MODE_RBR = 3'b110;

    // Wide enough for accumulator plus one beat's worth without losing the carry.
    localparam int PC_W  = $clog2(2 * DATA_W + 1);
    localparam int SUM_W = ((ACC_W > PC_W) ? ACC_W : PC_W) + 1;

    logic [1:0]               state_q, state_d;
    logic [2:0]               mode_q, mode_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic [LEN_W-1:0]         cnt_q, cnt_d;
    logic [NUM_CH*ACC_W-1:0]  acc_q, acc_d;
    logic [NUM_CH*ACC_W-1:0]  out_data_q, out_data_d;
    logic                     mode_err_q, mode_err_d;

    logic                     beat_acc;
    logic                     first_beat;
    logic [2:0]               cur_mode;
    logic [LEN_W-1:0]         cur_len;
    logic [LEN_W-1:0]         beat_idx;
    logic                     mode_ok;
    logic                     last_beat;
    logic [NUM_CH*ACC_W-1:0]  acc_new;

    function automatic logic [SUM_W-1:0] popcnt(input logic [DATA_W-1:0] v);
        logic [SUM_W-1:0] n;
        n = '0;
        for (int i = 0; i < DATA_W; i++) begin
            n = n + SUM_W'(v[i]);
        end
        return n;
    endfunction

    assign in_ready_o  = (state_q == HOLD) ? out_ready_i : 1'b1;
    assign out_valid_o = (state_q == HOLD);
    assign out_data_o  = out_data_q;
    assign mode_err_o  = mode_err_q;

    // Beat decode: the first beat of a group uses live mode/length, later beats the latched ones.
    always_comb begin
        beat_acc   = in_valid_i & in_ready_o;
        first_beat = (state_q != ACCUM);
        cur_mode   = first_beat ? pim_mode_i : mode_q;
        cur_len    = first_beat ? acc_len_i : len_q;
        beat_idx   = first_beat ? '0 : cnt_q;
        mode_ok    = (cur_mode == MODE_PAR) || (cur_mode == MODE_RBR);
        last_beat  = (beat_idx == cur_len);
    end

    // Per-channel accumulate; a new group starts from zero.
    always_comb begin
        logic [SUM_W-1:0] base;
        logic [SUM_W-1:0] val;
        logic [SUM_W-1:0] sum;
        acc_new = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            base = first_beat ? '0 : SUM_W'(acc_q[c*ACC_W +: ACC_W]);
            val  = popcnt(data_1_i[c*DATA_W +: DATA_W]);
            if (cur_mode == MODE_PAR) begin
                val = val + popcnt(data_2_i[c*DATA_W +: DATA_W]);
            end
            sum = base + val;
`ifdef PIM_ENC_ACC_SAT_EN
            // Once clamped, further non-negative beats keep it clamped.
            if (sum > SUM_W'({ACC_W{1'b1}})) begin
                acc_new[c*ACC_W +: ACC_W] = {ACC_W{1'b1}};
            end else begin
                acc_new[c*ACC_W +: ACC_W] = ACC_W'(sum);
            end
`else
            acc_new[c*ACC_W +: ACC_W] = ACC_W'(sum);
`endif
        end
    end

    // Next-state: group sequencing, result capture and mode error pulse.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        mode_err_d = 1'b0;

        if ((state_q == HOLD) && out_ready_i) begin
            state_d = IDLE;
        end

        if (beat_acc) begin
            if (first_beat && !mode_ok) begin
                mode_err_d = 1'b1;
                state_d    = IDLE;
            end else begin
                mode_d = cur_mode;
                len_d  = cur_len;
                cnt_d  = beat_idx + LEN_W'(1);
                acc_d  = acc_new;
                if (last_beat) begin
                    out_data_d = acc_new;
                    state_d    = HOLD;
                end else begin
                    state_d = ACCUM;
                end
            end
        end
    end

    // State registers with asynchronous clear; a partial group is dropped on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            mode_q     <= 3'b000;
            len_q      <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            mode_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            mode_err_q <= mode_err_d;
        end
    end

endmodule

// File: tb/tb_pim_encoder_acc.sv
// Testbench for pim_encoder_acc: directed scenarios plus randomized beats,
// checked by a group-level reference model feeding a scoreboard queue.
module tb_pim_encoder_acc;

    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 8;
    localparam int ACC_W   = 12;
    localparam int LEN_W   = 4;
    localparam int S_ACC_W = 4;

    localparam logic [2:0] PAR = 3'b101;
    localparam logic [2:0] RBR = 3'b110;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]               mode;
    logic [LEN_W-1:0]         len;
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_CH*DATA_W-1:0] d1, d2;
    logic                     out_valid;
    logic                     out_ready;
    logic [NUM_CH*ACC_W-1:0]  out_data;
    logic                     mode_err;

    logic dir_ready, rnd_ready, rnd_on;
    assign out_ready = rnd_on ? rnd_ready : dir_ready;

    logic [2:0]                 s_mode;
    logic [LEN_W-1:0]           s_len;
    logic                       s_in_valid, s_in_ready;
    logic [NUM_CH*DATA_W-1:0]   s_d1, s_d2;
    logic                       s_out_valid;
    logic                       s_out_ready;
    logic [NUM_CH*S_ACC_W-1:0]  s_out_data;
    logic                       s_mode_err;

    pim_encoder_acc #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .pim_mode_i(mode), .acc_len_i(len),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .data_1_i(d1), .data_2_i(d2),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .mode_err_o(mode_err)
    );

    // Narrow-accumulator instance for overflow behaviour.
    pim_encoder_acc #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ACC_W(S_ACC_W), .LEN_W(LEN_W)
    ) u_dut_small (
        .clk_i(clk), .rst_ni(rst_ni), .pim_mode_i(s_mode), .acc_len_i(s_len),
        .in_valid_i(s_in_valid), .in_ready_o(s_in_ready), .data_1_i(s_d1), .data_2_i(s_d2),
        .out_valid_o(s_out_valid), .out_ready_i(s_out_ready), .out_data_o(s_out_data),
        .mode_err_o(s_mode_err)
    );

    typedef struct {
        logic [NUM_CH*ACC_W-1:0] data;
        int                      t;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    int       cyc = 0;
    bit       holding = 1'b0;
    bit       in_group = 1'b0;
    logic [2:0] g_mode;
    int       g_len, g_cnt;
    int       g_sum[NUM_CH];
    int       err_cyc = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int acc_fold(input int s, input int w);
`ifdef PIM_ENC_ACC_SAT_EN
        return (s > (1 << w) - 1) ? (1 << w) - 1 : s;
`else
        return s % (1 << w);
`endif
    endfunction

    // Reference model: a group is len+1 accepted beats; its result appears next cycle.
    initial begin
        forever begin
            @(posedge clk or negedge rst_ni);
            if (!rst_ni) begin
                holding  = 1'b0;
                in_group = 1'b0;
                err_cyc  = -1;
                q.delete();
            end else begin
                bit   consume, accept;
                exp_t e;
                cyc++;
                consume = holding && out_ready;
                accept  = in_valid && (!holding || out_ready);
                if (consume) holding = 1'b0;
                if (accept) begin
                    if (!in_group) begin
                        if (mode != PAR && mode != RBR) begin
                            err_cyc = cyc;
                        end else begin
                            in_group = 1'b1;
                            g_mode   = mode;
                            g_len    = int'(len);
                            g_cnt    = 0;
                            for (int c = 0; c < NUM_CH; c++) g_sum[c] = 0;
                        end
                    end
                    if (in_group) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            g_sum[c] += $countones(d1[c*DATA_W +: DATA_W]);
                            if (g_mode == PAR) g_sum[c] += $countones(d2[c*DATA_W +: DATA_W]);
                        end
                        if (g_cnt == g_len) begin
                            e.data = '0;
                            for (int c = 0; c < NUM_CH; c++)
                                e.data[c*ACC_W +: ACC_W] = ACC_W'(acc_fold(g_sum[c], ACC_W));
                            e.t = cyc;
                            q.push_back(e);
                            holding  = 1'b1;
                            in_group = 1'b0;
                        end else begin
                            g_cnt++;
                        end
                    end
                end
            end
        end
    end

    // Monitor: compare DUT outputs against the scoreboard at each falling edge.
    initial begin
        bit last_valid, popped, fresh;
        last_valid = 1'b0;
        popped     = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                last_valid = 1'b0;
                popped     = 1'b0;
            end else begin
                chk("in_ready", 64'(in_ready), 64'(holding ? out_ready : 1'b1));
                chk("mode_err", 64'(mode_err), 64'(err_cyc == cyc));
                chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
                if (out_valid && q.size() != 0) begin
                    fresh = !last_valid || popped;
                    if (fresh) chk("latency_cycle", 64'(cyc), 64'(q[0].t));
                    chk("out_data", 64'(out_data), 64'(q[0].data));
                    popped = out_ready;
                    if (out_ready) void'(q.pop_front());
                end else begin
                    popped = 1'b0;
                end
                last_valid = out_valid;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_ready = ($urandom_range(9) < 7);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one beat from just after a rising edge and hold it until accepted.
    task automatic send_beat(input logic [2:0] m, input int l,
                             input logic [31:0] a, input logic [31:0] b);
        int n;
        in_valid = 1'b1;
        mode     = m;
        len      = LEN_W'(l);
        d1       = a;
        d2       = b;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no in_ready expected acceptance within 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int exp_s, r, n;
        logic [2:0] m;
        logic [NUM_CH*S_ACC_W-1:0] s_exp;

        in_valid = 0; mode = RBR; len = '0; d1 = '0; d2 = '0;
        dir_ready = 1'b1; rnd_on = 1'b0;
        s_in_valid = 0; s_mode = RBR; s_len = '0; s_d1 = '0; s_d2 = '0; s_out_ready = 1'b1;

        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_mode_err", 64'(mode_err), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        step(1);

        // RBR single beat: 8 per channel
        send_beat(RBR, 0, {NUM_CH{8'hFF}}, $urandom);
        // PARALLEL group of four beats, no bubble after the previous result
        repeat (4) send_beat(PAR, 3, {NUM_CH{8'h0F}}, {NUM_CH{8'h01}});
        step(3);

        // Back-pressure: result held while a new beat waits
        dir_ready = 1'b0;
        send_beat(RBR, 0, 32'h1234_5678, 32'h0);
        fork
            send_beat(PAR, 0, 32'hF0F0_0001, 32'h8000_00FF);
            begin
                step(4);
                dir_ready = 1'b1;
            end
        join
        step(3);

        // Unsupported mode is dropped and flagged; next RBR group is clean
        send_beat(3'b011, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send_beat(RBR, 1, 32'h0103_070F, 32'h0);
        send_beat(PAR, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step(3);

        // Overflow on narrow instance: RBR, len 2, three beats of 8 ones
        chk("small_in_ready", 64'(s_in_ready), 64'd1);
        s_mode = RBR; s_len = LEN_W'(2); s_d1 = {NUM_CH{8'hFF}}; s_in_valid = 1'b1;
        step(3);
        s_in_valid = 1'b0;
        @(negedge clk);
        exp_s = acc_fold(24, S_ACC_W);
        for (int c = 0; c < NUM_CH; c++) s_exp[c*S_ACC_W +: S_ACC_W] = S_ACC_W'(exp_s);
        chk("overflow_valid", 64'(s_out_valid), 64'd1);
        chk("overflow_data", 64'(s_out_data), 64'(s_exp));
        chk("overflow_no_err", 64'(s_mode_err), 64'd0);
        step(1);
        @(negedge clk);
        chk("overflow_consumed", 64'(s_out_valid), 64'd0);
        step(1);

        // Reset after two of four beats
        send_beat(PAR, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send_beat(PAR, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_data", 64'(out_data), 64'd0);
        chk("midrst_mode_err", 64'(mode_err), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_ni = 1'b1;
        step(1);
        repeat (4) send_beat(RBR, 3, 32'h0000_0101, 32'hFFFF_FFFF);
        step(2);

        // Randomized beats with random back-pressure
        rnd_on = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) step(1);
            r = $urandom_range(9);
            if (r == 0) m = 3'($urandom_range(7));
            else if (r < 5) m = PAR;
            else m = RBR;
            send_beat(m, $urandom_range(5), $urandom, $urandom);
        end
        rnd_on    = 1'b0;
        dir_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            n++;
            step(1);
        end
        chk("drain", 64'(q.size()), 64'd0);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
